// File: rtl/ram_bridge_pkg.sv
// ram_bridge shared definitions: bus widths, word types, FSM state encoding,
// the zero word constant and the saturating increment used by the timeout counter.
// Build option: RAM_BRIDGE_POST_WRITE_EN (posted writes, enables the POST state).
package ram_bridge_pkg;

  localparam int DATA_W = 32;   // data bus width
  localparam int ADDR_W = 32;   // byte address width
  localparam int SEL_W  = 4;    // byte lane enables
  localparam int CNT_W  = 8;    // timeout counter width

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam data_t ZERO_WORD = '0;

  // 2-bit state encoding; POST is only reachable with posted writes enabled
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_POST = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/ram_bridge_if.sv
// Memory-slave side of ram_bridge: held request plus one-cycle acknowledge.
// master = the bridge, slave = the memory (or a bench model of it).
interface ram_bridge_if;
  import ram_bridge_pkg::*;

  logic  mem_req_o;
  logic  mem_we_o;
  addr_t mem_addr_o;
  sel_t  mem_sel_o;
  data_t mem_data_o;
  data_t mem_data_i;
  logic  mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );

endinterface

// File: rtl/ram_bridge_timeout.sv
// Clear/enable saturating 8-bit counter for ram_bridge. expired is raised in
// the request cycle that would be cycle number LIMIT, so a request that is
// never acknowledged stays up exactly LIMIT cycles. LIMIT=0 never expires.
module ram_bridge_timeout
  import ram_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  cnt_t count_reg;

  // Count waiting cycles; clear has priority, saturate at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= sat_inc(count_reg);
    end
  end

  // count holds the number of completed waiting cycles, so the current one is count+1
  assign expired = (LIMIT != 0) && ((32'(count_reg) + 32'd1) >= LIMIT);

endmodule

// File: rtl/ram_bridge.sv
// ram_bridge: turns a single-cycle CPU data-RAM access into a held req/ack
// transaction, stalling the CPU until the slave acknowledges or the timeout
// expires. Optional macro RAM_BRIDGE_POST_WRITE_EN lets writes complete
// towards the CPU immediately while the bridge finishes them in POST.
module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_ce_i,
  input  logic          cpu_we_i,
  input  addr_t         cpu_addr_i,
  input  sel_t          cpu_sel_i,
  input  data_t         cpu_data_i,
  output data_t         cpu_data_o,
  output logic          stall_req_o,
  output logic          bus_err_o,
  ram_bridge_if.master  mem
);

  state_e state_reg;
  logic   mem_req_reg;
  logic   we_reg;
  addr_t  addr_reg;
  sel_t   sel_reg;
  data_t  wdata_reg;
  data_t  rdata_reg;
  logic   bus_err_reg;

  logic   tmo_clr;
  logic   tmo_en;
  logic   tmo_expired;

  // A new access restarts the wait count; it runs only while a request is out
  assign tmo_clr = (state_reg == ST_IDLE) && cpu_ce_i;
  assign tmo_en  = (state_reg == ST_REQ) || (state_reg == ST_POST);

  ram_bridge_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Access FSM with registered request, captured access and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      mem_req_reg <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      sel_reg     <= '0;
      wdata_reg   <= ZERO_WORD;
      rdata_reg   <= ZERO_WORD;
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cpu_ce_i) begin
            we_reg      <= cpu_we_i;
            addr_reg    <= cpu_addr_i;
            sel_reg     <= cpu_sel_i;
            wdata_reg   <= cpu_data_i;
            mem_req_reg <= 1'b1;
`ifdef RAM_BRIDGE_POST_WRITE_EN
            state_reg   <= cpu_we_i ? ST_POST : ST_REQ;
`else
            state_reg   <= ST_REQ;
`endif
          end
        end
        ST_REQ: begin
          // ack is checked first so a same-cycle timeout is not reported
          if (mem.mem_ack_i) begin
            rdata_reg   <= we_reg ? ZERO_WORD : mem.mem_data_i;
            mem_req_reg <= 1'b0;
            state_reg   <= ST_DONE;
          end else if (tmo_expired) begin
            rdata_reg   <= ZERO_WORD;
            bus_err_reg <= 1'b1;
            mem_req_reg <= 1'b0;
            state_reg   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
`ifdef RAM_BRIDGE_POST_WRITE_EN
        ST_POST: begin
          // the CPU already moved on, so only the error pulse reports a lost write
          if (mem.mem_ack_i || tmo_expired) begin
            bus_err_reg <= !mem.mem_ack_i;
            mem_req_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_reg   <= ST_IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  // Stall the pipeline for the whole access except its DONE cycle
`ifdef RAM_BRIDGE_POST_WRITE_EN
  assign stall_req_o = cpu_ce_i && (state_reg != ST_DONE) &&
                       !((state_reg == ST_IDLE) && cpu_we_i);
`else
  assign stall_req_o = cpu_ce_i && (state_reg != ST_DONE);
`endif

  assign cpu_data_o     = rdata_reg;
  assign bus_err_o      = bus_err_reg;
  assign mem.mem_req_o  = mem_req_reg;
  assign mem.mem_we_o   = we_reg;
  assign mem.mem_addr_o = addr_reg;
  assign mem.mem_sel_o  = sel_reg;
  assign mem.mem_data_o = wdata_reg;

endmodule

// File: tb/tb_ram_bridge.sv
// Bench for ram_bridge: directed scenarios plus randomized accesses checked
// against a cycle-count model (stall = min(lat,T)+1, req = min(lat,T), ...).
// Honours RAM_BRIDGE_POST_WRITE_EN when the build defines it.
module tb_ram_bridge;
  import ram_bridge_pkg::*;

  localparam int TMO = 4;
`ifdef RAM_BRIDGE_POST_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst;
  logic  ce, we;
  addr_t addr;
  sel_t  sel;
  data_t wdata;
  data_t cpu_data;
  logic  stall, bus_err;
  data_t last_rdata;

  int checks = 0;
  int failures = 0;

  ram_bridge_if bus();

  ram_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_ce_i    (ce),
    .cpu_we_i    (we),
    .cpu_addr_i  (addr),
    .cpu_sel_i   (sel),
    .cpu_data_i  (wdata),
    .cpu_data_o  (cpu_data),
    .stall_req_o (stall),
    .bus_err_o   (bus_err),
    .mem         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU access against a slave acking on REQ cycle 'lat' (never if lat > TMO).
  // Called on a negedge with the bridge idle; returns on a negedge after one idle gap.
  task automatic do_access(input logic w, input addr_t a, input sel_t s, input data_t d,
                           input int lat, input data_t rd);
    int    nstall = 0, nreq = 0, bad = 0, nerr = 0;
    bit    done = 1'b0;
    bit    tmo = (lat > TMO);
    int    exp_req = tmo ? TMO : lat;
    data_t exp_rd = (tmo || w) ? ZERO_WORD : rd;
    ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
    bus.mem_ack_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus.mem_req_o) begin
        nreq++;
        if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o, bus.mem_data_o} !== {w, a, s, d}) bad++;
      end
      if (!stall) begin
        done = 1'b1;
        check("done_rdata", cpu_data, exp_rd);
        check("done_err", 32'(bus_err), 32'(tmo));
      end else begin
        nstall++;
        if (bus_err) nerr++;
      end
      bus.mem_ack_i  = bus.mem_req_o && (nreq == lat);
      bus.mem_data_i = bus.mem_ack_i ? rd : data_t'($urandom());
      @(negedge clk);
    end
    if (!done) check("access_budget", 32'(0), 32'(1));
    check("stall_cycles", 32'(nstall), 32'(exp_req + 1));
    check("req_cycles", 32'(nreq), 32'(exp_req));
    check("req_fields", 32'(bad), 32'(0));
    check("err_early", 32'(nerr), 32'(0));
    ce = 1'b0; bus.mem_ack_i = 1'b0;
    #1;
    check("gap_req", 32'(bus.mem_req_o), 32'(0));
    check("gap_err", 32'(bus_err), 32'(0));
    last_rdata = exp_rd;
    $display("access we=%0d addr=%h sel=%h lat=%0d stall=%0d req=%0d rdata=%h", w, a, s, lat, nstall, nreq, cpu_data);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    last_rdata = ZERO_WORD;

    // Reset values
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_req", 32'(bus.mem_req_o), 32'(0));
    check("rst_we", 32'(bus.mem_we_o), 32'(0));
    check("rst_addr", bus.mem_addr_o, 32'(0));
    check("rst_sel", 32'(bus.mem_sel_o), 32'(0));
    check("rst_wdata", bus.mem_data_o, 32'(0));
    check("rst_rdata", cpu_data, 32'(0));
    check("rst_err", 32'(bus_err), 32'(0));
    check("rst_stall_lo", 32'(stall), 32'(0));
    ce = 1'b1;
    #1;
    check("rst_stall_hi", 32'(stall), 32'(1));
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Read acked on first REQ cycle
    do_access(1'b0, 32'h40, 4'hF, 32'h0, 1, 32'hDEADBEEF);
`ifndef RAM_BRIDGE_POST_WRITE_EN
    // Blocking write acked on third REQ cycle
    do_access(1'b1, 32'h100, 4'b0011, 32'h12345678, 3, 32'h55AA55AA);
`endif
    // Timeout, and ack landing on the timeout cycle
    do_access(1'b0, 32'h200, 4'hF, 32'h0, 99, 32'h77777777);
    do_access(1'b0, 32'h204, 4'h1, 32'h0, TMO, 32'h0BADF00D);

    // Reset during the second REQ cycle
    ce = 1'b1; we = 1'b0; addr = 32'h300; sel = 4'hF; wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    #1;
    check("pre_rst_req", 32'(bus.mem_req_o), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus.mem_req_o), 32'(0));
    check("mid_rst_stall", 32'(stall), 32'(1));
    check("mid_rst_rdata", cpu_data, 32'(0));
    last_rdata = ZERO_WORD;
    @(negedge clk);
    rst = 1'b0;
    do_access(1'b0, 32'h300, 4'hF, 32'h0, 2, 32'h31415926);

    // Spurious ack while idle is ignored
    bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h11112222;
    @(negedge clk);
    #1;
    check("spur_req", 32'(bus.mem_req_o), 32'(0));
    check("spur_rdata", cpu_data, last_rdata);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    do_access(1'b0, 32'h44, 4'hF, 32'h0, 1, 32'hA5A5A5A5);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      logic w;
      w = POSTED ? 1'b0 : 1'($urandom_range(0, 1));
      do_access(w, addr_t'($urandom()), sel_t'($urandom_range(0, 15)), data_t'($urandom()),
                int'($urandom_range(1, TMO + 2)), data_t'($urandom()));
    end

`ifdef RAM_BRIDGE_POST_WRITE_EN
    // Posted write followed at once by a read of the same address, slave latency 2
    begin
      int   nstall = 0, run = 0;
      bit   done = 1'b0;
      logic order[$];
      ce = 1'b1; we = 1'b1; addr = 32'h100; sel = 4'hF; wdata = 32'hCAFEF00D;
      #1;
      check("post_nostall", 32'(stall), 32'(0));
      @(negedge clk);
      we = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
        #1;
        if (!stall) begin
          done = 1'b1;
          check("post_rdata", cpu_data, 32'h5A5A0001);
        end else begin
          nstall++;
        end
        run = bus.mem_req_o ? run + 1 : 0;
        if (run == 1) order.push_back(bus.mem_we_o);
        bus.mem_ack_i  = (run == 2);
        bus.mem_data_i = bus.mem_ack_i ? 32'h5A5A0001 : data_t'($urandom());
        @(negedge clk);
      end
      ce = 1'b0; bus.mem_ack_i = 1'b0;
      check("post_done", 32'(done), 32'(1));
      check("post_stall", 32'(nstall), 32'(5));
      check("post_nreq", 32'(order.size()), 32'(2));
      if (order.size() == 2) begin
        check("post_first_we", 32'(order[0]), 32'(1));
        check("post_second_we", 32'(order[1]), 32'(0));
      end
      $display("posted write then read stall=%0d rdata=%h", nstall, cpu_data);
      @(negedge clk);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bridge.md
# ram_bridge

Multi-cycle data-memory bridge between the CPU's single-access data-RAM port and a req/ack handshaked memory slave. It sits directly downstream of the CPU's MEM-stage RAM port, in place of a direct CPU-to-RAM connection. It converts each CPU access into a held request, and raises a stall request to the CPU until the slave acknowledges or a timeout expires. It also provides an optional posted-write mode.

## Interface
- TIMEOUT_CYCLES, 255, max REQ cycles awaiting ack; 0 disables timeout
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_ce_i  in  1  CPU access valid, held stable while stall_req_o=1
- cpu_we_i  in  1  1=write, 0=read
- cpu_addr_i  in  32  byte address (`DataAddrBus)
- cpu_sel_i  in  4  byte lane enables
- cpu_data_i  in  32  write data (`DataBus)
- cpu_data_o  out  32  read data returned to CPU
- stall_req_o  out  1  combinational stall request to CPU pipeline
- mem_req_o  out  1  request to slave, registered
- mem_we_o, mem_addr_o, mem_sel_o, mem_data_o  out  1/32/4/32  registered copies of captured access
- mem_data_i  in  32  slave read data, valid with mem_ack_i
- mem_ack_i  in  1  slave completion, one-cycle pulse
- bus_err_o  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, REQ, DONE, plus POST when the macro is on.
- IDLE, cpu_ce_i=1:
  - capture we/addr/sel/data into the mem_* registers
  - clear the timeout counter
  - next state REQ
- IDLE, cpu_ce_i=0: stay in IDLE.
- REQ:
  - mem_req_o=1
  - mem_* outputs held constant
  - counter increments each cycle
- REQ, mem_ack_i=1:
  - rdata <= mem_data_i for a read; rdata <= 0 for a write
  - next state DONE
- REQ, counter reaches TIMEOUT_CYCLES (nonzero) with no ack:
  - rdata <= 0, next state DONE
  - bus_err_o=1 during that DONE cycle
- DONE: mem_req_o=0; next state IDLE unconditionally.
- stall_req_o = cpu_ce_i && (state != DONE); the CPU advances at the end of the DONE cycle.
- cpu_data_o = rdata.
- Ack and timeout in the same cycle: the ack wins and bus_err_o stays 0.
- mem_ack_i outside REQ/POST is ignored.
- Reset outputs:
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_sel_o=0, mem_data_o=0
  - cpu_data_o=0, bus_err_o=0
  - stall_req_o follows cpu_ce_i
- Reset internal state: state=IDLE, counter=0.
- Reset mid-request abandons the access; the slave must tolerate a dropped request.

## Timing
- Ack on the k-th REQ cycle (k>=1):
  - stall_req_o high for k+1 cycles (IDLE + k REQ)
  - DONE follows; total access occupies k+2 cycles
  - mem_req_o high exactly k cycles
- Timeout: mem_req_o high TIMEOUT_CYCLES cycles; stall for TIMEOUT_CYCLES+1 cycles.
- The minimum gap between consecutive accesses is one IDLE cycle after DONE.
- The counter is 8 bits and saturates; it never wraps.

## Configuration
- RAM_BRIDGE_POST_WRITE_EN defined:
  - A write seen in IDLE is captured, and stall_req_o=0 in that cycle; the CPU proceeds.
  - The next state is POST, where mem_req_o=1 until ack or timeout, then IDLE.
  - Timeout in POST pulses bus_err_o for one cycle.
  - Any cpu_ce_i during POST gives stall_req_o=1 until the return to IDLE; the access is then handled normally.
  - Reads are unchanged.
- RAM_BRIDGE_POST_WRITE_EN undefined: no POST state; writes block exactly like reads.

## Structure
- The shared defines include holds `DataBus, `DataAddrBus, the state encodings (2-bit: IDLE=0, REQ=1, DONE=2, POST=3) and a zero word constant.
- One sub-module, ram_bridge_timeout: the clear/enable saturating counter with an expired flag.
- The FSM and capture registers stay in ram_bridge.

## Test plan
- Read addr 0x40, ack on 1st REQ cycle with 0xDEADBEEF:
  - stall_req_o high 2 cycles
  - cpu_data_o=0xDEADBEEF in DONE
  - mem_req_o high 1 cycle
- Write addr 0x100, sel 4'b0011, data 0x12345678, ack on 3rd REQ cycle:
  - mem_we_o=1; mem_sel_o/mem_addr_o/mem_data_o stable for 3 cycles
  - stall 4 cycles; cpu_data_o=0
- TIMEOUT_CYCLES=4, no ack:
  - mem_req_o high 4 cycles
  - bus_err_o pulses once in DONE
  - cpu_data_o=0; stall 5 cycles
- Reset asserted during 2nd REQ cycle:
  - mem_req_o drops to 0 asynchronously
  - after release with cpu_ce_i still 1, the request restarts from IDLE
- Spurious mem_ack_i in IDLE, then a read acked with 0xA5A5A5A5: the spurious ack is ignored and the read returns 0xA5A5A5A5.
- Macro on; write 0x100 then immediately a read of 0x100, slave ack latency 2:
  - the write causes no stall
  - the read stalls through POST and then its own REQ
  - the slave sees the write before the read
